mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single 256-bit line-wide data memory port between two cache controllers: requester 0 (instruction cache) and requester 1 (data cache). Each requester uses the same enable/write/addr/data/ack handshake the caches already drive toward memory. The block grants the port with round-robin fairness and holds the grant for a whole transaction. It routes ack and read data back only to the granted requester and keeps saturating per-requester transaction counters for performance analysis.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cache line width in bits
CNT_W, 16, width of each transaction counter

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  asynchronous active-low reset
m0_enable_i  in  1  requester 0 request; held high until m0_ack_o
m0_write_i  in  1  requester 0: 1=line write, 0=line read
m0_addr_i  in  ADDR_W  requester 0 line address
m0_data_i  in  LINE_W  requester 0 write data
m0_data_o  out  LINE_W  read data to requester 0
m0_ack_o  out  1  transaction complete for requester 0
m1_enable_i / m1_write_i / m1_addr_i / m1_data_i / m1_data_o / m1_ack_o: same as m0_* for requester 1
mem_enable_o  out  1  to data memory
mem_write_o  out  1  to data memory
mem_addr_o  out  ADDR_W  to data memory
mem_data_o  out  LINE_W  to data memory
mem_data_i  in  LINE_W  from data memory
mem_ack_i  in  1  from data memory
grant_o  out  2  one-hot current owner; 00 when idle or in the release cycle
m0_count_o  out  CNT_W  completed requester-0 transactions, saturating
m1_count_o  out  CNT_W  completed requester-1 transactions, saturating

Behaviour:
- Reset (rst_i=0, asynchronous) puts the block in state IDLE, with last=1 (requester 0 wins the first tie) and both counters at 0.
- Reset value of every output is 0: grant_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, m*_ack_o, m*_data_o, counters.
- States:
  - IDLE: grant_o=00 and mem_enable_o=0.
    - Only one enable high: go to GRANT of that requester next cycle.
    - Both enables high: grant the requester that is not `last`.
    - Neither enable high: stay in IDLE.
  - GRANT0 / GRANT1: grant_o is one-hot.
    - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o combinationally follow the owner's inputs.
    - The owner's ack_o equals mem_ack_i. The non-owner's ack_o is 0.
  - RELEASE: one cycle with mem_enable_o=0 and grant_o=00, so the memory sees enable drop between transactions. Then go to IDLE.
- Completion: in GRANTx with mem_ack_i=1:
  - set last=x and increment mx_count_o;
  - go to RELEASE.
- Abort: in GRANTx with mx_enable_i=0 and mem_ack_i=0:
  - go to RELEASE;
  - no count increment, and last is unchanged.
- Ack and enable drop in the same cycle counts as a completion.
- Read data: m0_data_o and m1_data_o both carry mem_data_i unconditionally. Requesters sample it only on their own ack.
- Non-owner outputs: while not granted, mem_* outputs other than mem_data_o are 0.
- mem_ack_i in IDLE or RELEASE is ignored: no ack to any requester and no count.
- Arbitration latency: a request seen in IDLE reaches memory 1 cycle later.
- Back-to-back: a requester re-requesting after completion waits ≥2 cycles (RELEASE, IDLE). If the other requester is pending, the other is served first.
- Multi-phase transactions: a data-cache writeback followed by its refill is two transactions. The refill may be preceded by a requester-0 transaction.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A request raised while the other requester holds the grant stays pending. No ack is given to it until it is granted.

Test Plan:
- Single read: m1_enable_i=1, write=0, addr=0x0000_0400; memory acks after 10 cycles with data 0xA5..A5 -> mem_addr_o=0x400 from cycle 1; m1_ack_o pulses once with m1_data_o=0xA5..A5; m1_count_o=1; then RELEASE and IDLE.
- Simultaneous requests after reset -> GRANT0 first. After ack, RELEASE, then GRANT1. The next simultaneous pair grants 0 again.
- Writeback then refill: m1 write to 0x800 then read from 0x400, with m0 pending throughout -> order m1 write, m0, m1 read; each mem_enable_o high phase is separated by ≥1 low cycle.
- Abort: m0 drops enable in the 3rd grant cycle before any ack -> RELEASE, m0_count_o unchanged, no ack, last unchanged.
- Spurious mem_ack_i=1 in IDLE -> both ack_o stay 0 and counters unchanged. Reset asserted mid-GRANT1 -> all outputs 0 immediately (asynchronously), state IDLE.
- Counter saturation with CNT_W=2: 5 completed m0 transactions -> m0_count_o stays at 3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one line-wide data memory port between requester 0 (instruction
// cache) and requester 1 (data cache). The port is granted round-robin and
// held for a whole transaction. After every transaction there is one RELEASE
// cycle, so memory always sees enable drop between transactions.
// Saturating counters record how many transactions each requester completed.
//
// Handshake (same on each requester side and on the memory side):
//   enable rises with write/addr/data valid and stays high with them stable
//   until ack. ack is a one-cycle pulse that completes the transaction. Read
//   data is valid only in the cycle ack is high. A requester may drop enable
//   before ack to abandon its transaction. Memory then sees enable fall with
//   no ack.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // requester 0 (instruction cache)
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic [LINE_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  // requester 1 (data cache)
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic [LINE_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  // shared data memory port
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  // status
  output logic [1:0]        grant_o,
  output logic [CNT_W-1:0]  m0_count_o,
  output logic [CNT_W-1:0]  m1_count_o,
  // debug view of the arbitration state (IDLE=0, GRANT0=1, GRANT1=2, RELEASE=3)
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  // r_last holds the requester that most recently completed. A tie in IDLE
  // goes to the other one. Reset value 1 lets requester 0 win the first tie.
  logic             r_last;
  logic             w_next_last;
  logic             w_done0;
  logic             w_done1;
  logic             w_own0;
  logic             w_own1;
  logic [CNT_W-1:0] r_m0_count;
  logic [CNT_W-1:0] r_m1_count;

  assign w_own0  = (r_state == ST_GRANT0);
  assign w_own1  = (r_state == ST_GRANT1);
  assign state_o = r_state;

  // State register and round-robin history
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
    end
  end

  // Next-state: arbitrate in IDLE, detect completion or abort while granted
  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last;
    w_done0      = 1'b0;
    w_done1      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_enable_i && m1_enable_i) begin
          w_next_state = r_last ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_enable_i) begin
          w_next_state = ST_GRANT0;
        end else if (m1_enable_i) begin
          w_next_state = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        // ack wins over a simultaneous enable drop: it is still a completion
        if (mem_ack_i) begin
          w_done0      = 1'b1;
          w_next_last  = 1'b0;
          w_next_state = ST_RELEASE;
        end else if (!m0_enable_i) begin
          w_next_state = ST_RELEASE;
        end
      end
      ST_GRANT1: begin
        if (mem_ack_i) begin
          w_done1      = 1'b1;
          w_next_last  = 1'b1;
          w_next_state = ST_RELEASE;
        end else if (!m1_enable_i) begin
          w_next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Memory-side mux: only the owner's request reaches memory, else all zero
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    if (w_own0) begin
      mem_enable_o = m0_enable_i;
      mem_write_o  = m0_write_i;
      mem_addr_o   = m0_addr_i;
      mem_data_o   = m0_data_i;
    end else if (w_own1) begin
      mem_enable_o = m1_enable_i;
      mem_write_o  = m1_write_i;
      mem_addr_o   = m1_addr_i;
      mem_data_o   = m1_data_i;
    end
  end

  // Requester-side returns: ack only to the owner. Read data is broadcast
  // and forced to zero while reset is asserted.
  always_comb begin
    grant_o   = {w_own1, w_own0};
    m0_ack_o  = w_own0 & mem_ack_i;
    m1_ack_o  = w_own1 & mem_ack_i;
    m0_data_o = rst_i ? mem_data_i : '0;
    m1_data_o = rst_i ? mem_data_i : '0;
  end

  // Saturating completed-transaction counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_m0_count <= '0;
      r_m1_count <= '0;
    end else begin
      if (w_done0 && (r_m0_count != CNT_MAX)) begin
        r_m0_count <= r_m0_count + CNT_ONE;
      end
      if (w_done1 && (r_m1_count != CNT_MAX)) begin
        r_m1_count <= r_m1_count + CNT_ONE;
      end
    end
  end

  assign m0_count_o = r_m0_count;
  assign m1_count_o = r_m1_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. A transaction-level model predicts every
// output each cycle. A queue holds the expected grant order. Directed
// scenarios cover reset, a single read, a spurious ack, an abort, tie-breaking,
// writeback/refill ordering, counter saturation and asynchronous reset.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              m0_enable_i = 1'b0, m0_write_i = 1'b0;
  logic [ADDR_W-1:0] m0_addr_i = '0;
  logic [LINE_W-1:0] m0_data_i = '0;
  logic [LINE_W-1:0] m0_data_o;
  logic              m0_ack_o;
  logic              m1_enable_i = 1'b0, m1_write_i = 1'b0;
  logic [ADDR_W-1:0] m1_addr_i = '0;
  logic [LINE_W-1:0] m1_data_i = '0;
  logic [LINE_W-1:0] m1_data_o;
  logic              m1_ack_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i = '0;
  logic              mem_ack_i = 1'b0;
  logic [1:0]        grant_o;
  logic [CNT_W-1:0]  m0_count_o, m1_count_o;
  logic [1:0]        state_o;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o), .m0_count_o(m0_count_o), .m1_count_o(m1_count_o),
    .state_o(state_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [1:0] exp_q[$];      // expected grant order, one-hot owners
  int ack0_pulses = 0;
  int ack1_pulses = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The port has an owner (-1 = none) or is cooling down for one cycle after
  // a transaction. Ties go to whoever did not finish last.
  int m_owner = -1;
  bit m_cool = 1'b0;
  int m_last = 1;
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  always @(posedge clk) begin
    if (!rst_i) begin
      m_owner = -1; m_cool = 1'b0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (m_owner < 0) begin
      if (m0_enable_i && m1_enable_i) m_owner = 1 - m_last;
      else if (m0_enable_i) m_owner = 0;
      else if (m1_enable_i) m_owner = 1;
    end else if (mem_ack_i) begin
      m_last = m_owner;
      if (m_owner == 0 && m_cnt0 < CNT_SAT) m_cnt0++;
      if (m_owner == 1 && m_cnt1 < CNT_SAT) m_cnt1++;
      m_owner = -1; m_cool = 1'b1;
    end else if ((m_owner == 0) ? !m0_enable_i : !m1_enable_i) begin
      m_owner = -1; m_cool = 1'b1;
    end
  end

  // Compare all outputs to the model every cycle, away from the clock edge
  always @(negedge clk) begin
    logic [1:0]        e_grant;
    logic              e_en, e_wr, e_ack0, e_ack1;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata, e_rdata;
    e_grant = 2'b00; e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_rdata = '0;
    if (rst_i) begin
      e_rdata = mem_data_i;
      if (m_owner == 0) begin
        e_grant = 2'b01; e_en = m0_enable_i; e_wr = m0_write_i;
        e_addr = m0_addr_i; e_wdata = m0_data_i; e_ack0 = mem_ack_i;
      end else if (m_owner == 1) begin
        e_grant = 2'b10; e_en = m1_enable_i; e_wr = m1_write_i;
        e_addr = m1_addr_i; e_wdata = m1_data_i; e_ack1 = mem_ack_i;
      end
    end
    check("grant_o", grant_o, e_grant);
    check("mem_enable_o", mem_enable_o, e_en);
    check("mem_write_o", mem_write_o, e_wr);
    check("mem_addr_o", mem_addr_o, e_addr);
    check("mem_data_o", mem_data_o, e_wdata);
    check("m0_ack_o", m0_ack_o, e_ack0);
    check("m1_ack_o", m1_ack_o, e_ack1);
    check("m0_data_o", m0_data_o, e_rdata);
    check("m1_data_o", m1_data_o, e_rdata);
    check("m0_count_o", m0_count_o, (rst_i ? m_cnt0 : 0));
    check("m1_count_o", m1_count_o, (rst_i ? m_cnt1 : 0));
  end

  // Grant-order scoreboard and ack pulse counting
  logic [1:0] prev_grant = 2'b00;
  always @(negedge clk) begin
    if (rst_i && grant_o != 2'b00 && prev_grant == 2'b00) begin
      if (exp_q.size() == 0) check("grant_order_extra", grant_o, 2'b00);
      else check("grant_order", grant_o, exp_q.pop_front());
    end
    prev_grant = grant_o;
    if (m0_ack_o) ack0_pulses++;
    if (m1_ack_o) ack1_pulses++;
  end

  // ---------------- memory responder ----------------
  bit                resp_on = 1'b0;
  bit                spur_ack = 1'b0;
  int                resp_lat = 4;
  int                resp_cnt = 0;
  logic [LINE_W-1:0] resp_data = '0;

  always @(posedge clk) begin
    #2;
    if (!resp_on) begin
      mem_ack_i = spur_ack; mem_data_i = resp_data; resp_cnt = 0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0; resp_cnt = 0;
    end else if (mem_enable_o) begin
      resp_cnt++;
      if (resp_cnt >= resp_lat) begin
        mem_ack_i = 1'b1; mem_data_i = resp_data; resp_cnt = 0;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int id, input bit en, input bit wr,
                           input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
    if (id == 0) begin
      m0_enable_i = en; m0_write_i = wr; m0_addr_i = addr; m0_data_i = wdata;
    end else begin
      m1_enable_i = en; m1_write_i = wr; m1_addr_i = addr; m1_data_i = wdata;
    end
  endtask

  // Full transaction: raise enable, wait (bounded) for ack, drop enable
  task automatic do_req(input int id, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wdata, output logic [LINE_W-1:0] rdata);
    bit got = 1'b0;
    int waited = 0;
    rdata = '0;
    @(posedge clk); #1;
    drive_req(id, 1'b1, wr, addr, wdata);
    while (!got && waited < 300) begin
      @(negedge clk);
      if ((id == 0) ? m0_ack_o : m1_ack_o) begin
        got = 1'b1;
        rdata = (id == 0) ? m0_data_o : m1_data_o;
      end
      waited++;
    end
    check((id == 0) ? "req0_ack_seen" : "req1_ack_seen", got, 1'b1);
    @(posedge clk); #1;
    drive_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
  initial begin
    logic [LINE_W-1:0] rd, rd0, rd1;
    int a1;

    // Reset: every output zero, even with memory data present
    resp_data = {8{32'hDEAD_BEEF}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant_o, 2'b00);
    check("rst_state_idle", state_o, 2'd0);
    check("rst_m0_data_gated", m0_data_o, '0);
    check("rst_m0_count", m0_count_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b1;

    // Spurious ack while idle: no ack, no count
    spur_ack = 1'b1;
    repeat (4) @(negedge clk);
    spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_ack0", ack0_pulses, 0);
    check("spur_ack1", ack1_pulses, 0);
    check("spur_cnt0", m0_count_o, 0);
    check("spur_cnt1", m1_count_o, 0);

    // Single read from requester 1
    resp_on = 1'b1; resp_lat = 10; resp_data = PAT_A5;
    exp_q.push_back(2'b10);
    do_req(1, 1'b0, 32'h0000_0400, '0, rd);
    check("single_rdata", rd, PAT_A5);
    repeat (2) @(negedge clk);
    check("single_ack1_pulses", ack1_pulses, 1);
    check("single_m1_count", m1_count_o, 1);
    check("single_back_idle", state_o, 2'd0);

    // Abort: requester 0 drops enable in its 3rd grant cycle
    exp_q.push_back(2'b01);
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 32'h0000_0100, '0);
    repeat (3) @(posedge clk);
    #1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("abort_m0_count", m0_count_o, 0);
    check("abort_no_ack0", ack0_pulses, 0);

    // Two simultaneous pairs: 0 wins each tie because 1 finished last
    resp_lat = 3;
    repeat (2) begin
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      fork
        do_req(0, 1'b0, 32'h0000_1000, '0, rd0);
        do_req(1, 1'b1, 32'h0000_2000, {8{32'h1234_5678}}, rd1);
      join
    end
    repeat (2) @(negedge clk);
    check("pairs_m0_count", m0_count_o, 2);
    check("pairs_m1_count", m1_count_o, 3);

    // Writeback then refill with requester 0 pending: order 1, 0, 1
    exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    fork
      begin
        do_req(1, 1'b1, 32'h0000_0800, {8{32'hCAFE_F00D}}, rd1);
        do_req(1, 1'b0, 32'h0000_0400, '0, rd1);
      end
      begin
        @(posedge clk);
        do_req(0, 1'b0, 32'h0000_3000, '0, rd0);
      end
    join
    repeat (2) @(negedge clk);
    check("wb_m0_count", m0_count_o, 3);
    check("wb_m1_count_sat", m1_count_o, 3);

    // Saturation: 5 more completions leave requester 0 at 3
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(2'b01);
      do_req(0, 1'b0, ADDR_W'(32'h40 * i), '0, rd0);
    end
    a1 = ack0_pulses;
    repeat (2) @(negedge clk);
    check("sat_m0_count", m0_count_o, 3);
    check("sat_ack0_pulses", a1, 1 + 2 + 5);

    // Asynchronous reset in the middle of a requester-1 grant
    resp_lat = 50;
    exp_q.push_back(2'b10);
    @(posedge clk); #1;
    drive_req(1, 1'b1, 1'b1, 32'h0000_0040, {8{32'h5555_AAAA}});
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_grant1", grant_o, 2'b10);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_grant", grant_o, 2'b00);
    check("arst_mem_enable", mem_enable_o, 1'b0);
    check("arst_mem_write", mem_write_o, 1'b0);
    check("arst_mem_addr", mem_addr_o, '0);
    check("arst_mem_data", mem_data_o, '0);
    check("arst_m1_ack", m1_ack_o, 1'b0);
    check("arst_m1_data", m1_data_o, '0);
    check("arst_m0_count", m0_count_o, 0);
    check("arst_m1_count", m1_count_o, 0);
    check("arst_state_idle", state_o, 2'd0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    resp_on = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);

    check("grant_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
